// File: rtl/alp_mdseq_if.sv
// alp_mdseq_if: groups the start/operand handshake and the ALP D/Q control
// fields driven by the multiply/divide step sequencer.
// Ports summary:
//   master = microsequencer side: drives start/op/count/stall/status and reads codes.
//   slave  = sequencer side: reads requests/status and drives the codes, busy and done.
interface alp_mdseq_if;
  // Request and datapath status (microsequencer / datapath -> sequencer)
  logic       start_h;
  logic       div_h;
  logic [5:0] count_h;
  logic       stall_h;
  logic       qlsb_h;
  logic       dsign_h;
  // ALP D/Q control and status (sequencer -> ALP decoder / microsequencer)
  logic [3:0] mux_h;
  logic [1:0] dq_h;
  logic       dmove_h;
  logic       dreg_inh_l;
  logic       alu_sub_h;
  logic       alu_pass_h;
  logic       busy_h;
  logic       done_h;

  modport master (
    output start_h, div_h, count_h, stall_h, qlsb_h, dsign_h,
    input  mux_h, dq_h, dmove_h, dreg_inh_l, alu_sub_h, alu_pass_h, busy_h, done_h
  );

  modport slave (
    input  start_h, div_h, count_h, stall_h, qlsb_h, dsign_h,
    output mux_h, dq_h, dmove_h, dreg_inh_l, alu_sub_h, alu_pass_h, busy_h, done_h
  );
endinterface

// File: rtl/alp_mdseq.sv
// alp_mdseq: multiply/divide step sequencer driving the ALP D/Q control fields.
// Latency: start edge to done_h = N+2 cycles (multiply), N+3 (divide), +1 per stall cycle.
// Backpressure: stall_h freezes LOAD/STEP/FIX with hold codes; start_h ignored unless IDLE.
// Ports:
//   clk      - clock
//   reset_h  - asynchronous active-high reset (forces IDLE and hold codes immediately)
//   bus      - alp_mdseq_if.slave: start/div/count/stall/qlsb/dsign in;
//              mux/dq/dmove/dreg_inh_l/alu_sub/alu_pass (combinational), busy/done (registered) out
module alp_mdseq #(
  parameter logic [3:0] MUX_HOLD  = 4'b0100,
  parameter logic [1:0] DQ_HOLD   = 2'b11,
  parameter logic [3:0] MUX_LOAD  = 4'b0000,
  parameter logic [3:0] MUX_MSTEP = 4'b0001,
  parameter logic [1:0] DQ_MSTEP  = 2'b01,
  parameter logic [3:0] MUX_DSTEP = 4'b0000,
  parameter logic [1:0] DQ_DSTEP  = 2'b10,
  parameter logic [3:0] MUX_FIX   = 4'b1001
) (
  input  logic        clk,
  input  logic        reset_h,
  alp_mdseq_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    STEP = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t     state;
  logic [5:0] cnt;      // remaining steps, including the current one
  logic       div_q;    // latched operation: 1 = divide
  logic       sign_q;   // partial remainder sign from the previous executed divide step
  logic       busy_q;
  logic       done_q;

  // Iteration count as loaded: 0 and anything above 32 become 32.
  logic [5:0] count_init;
  assign count_init = ((bus.count_h == 6'd0) || (bus.count_h > 6'd32)) ? 6'd32 : bus.count_h;

  // Stall only freezes the active datapath states; IDLE and DONE ignore it.
  logic frozen;
  assign frozen = bus.stall_h && ((state == LOAD) || (state == STEP) || (state == FIX));

  // ---------------------------------------------------------------------------
  // Sequencer state, counter, sign flag and registered busy/done.
  // busy/done are set on the transition into their states so they line up with
  // the state register without any extra decode.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset_h) begin
    if (reset_h) begin
      state  <= IDLE;
      cnt    <= 6'd0;
      div_q  <= 1'b0;
      sign_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          busy_q <= 1'b0;
          if (bus.start_h) begin
            div_q  <= bus.div_h;
            cnt    <= count_init;
            sign_q <= 1'b0;
            state  <= LOAD;
            busy_q <= 1'b1;
          end
        end

        LOAD: begin
          if (!bus.stall_h) begin
            state <= STEP;
          end
        end

        STEP: begin
          if (!bus.stall_h) begin
            if (div_q) begin
              sign_q <= bus.dsign_h;
            end
            // Exit on the last executed step; the counter never goes below 1.
            if (cnt == 6'd1) begin
              if (div_q) begin
                state <= FIX;
              end else begin
                state  <= DONE;
                done_q <= 1'b1;
              end
            end else begin
              cnt <= cnt - 6'd1;
            end
          end
        end

        FIX: begin
          if (!bus.stall_h) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end

        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // ALP control code decode: combinational from state, stall and status so the
  // ALU operation follows the live Q[0] / D sign within the same cycle.
  // ---------------------------------------------------------------------------
  logic [3:0] mux_c;
  logic [1:0] dq_c;
  logic       dmove_c;
  logic       inh_c;
  logic       sub_c;
  logic       pass_c;

  always_comb begin
    mux_c   = MUX_HOLD;
    dq_c    = DQ_HOLD;
    dmove_c = 1'b0;
    inh_c   = 1'b0;
    sub_c   = 1'b0;
    pass_c  = 1'b0;
    if (!frozen) begin
      case (state)
        LOAD: begin
          mux_c   = MUX_LOAD;
          dmove_c = 1'b1;
        end
        STEP: begin
          inh_c = 1'b1;
          if (div_q) begin
            // Non-restoring: subtract while the remainder is non-negative.
            mux_c = MUX_DSTEP;
            dq_c  = DQ_DSTEP;
            sub_c = ~sign_q;
          end else begin
            // Shift-and-add: skip the add when the multiplier bit is 0.
            mux_c  = MUX_MSTEP;
            dq_c   = DQ_MSTEP;
            pass_c = ~bus.qlsb_h;
          end
        end
        FIX: begin
          mux_c = MUX_FIX;
          // Restoring add only when the final remainder went negative.
          inh_c = sign_q;
        end
        default: begin
          mux_c = MUX_HOLD;
        end
      endcase
    end
  end

  assign bus.mux_h      = mux_c;
  assign bus.dq_h       = dq_c;
  assign bus.dmove_h    = dmove_c;
  assign bus.dreg_inh_l = inh_c;
  assign bus.alu_sub_h  = sub_c;
  assign bus.alu_pass_h = pass_c;
  assign bus.busy_h     = busy_q;
  assign bus.done_h     = done_q;

endmodule
